// File: rtl/lzc_if.sv
// Bundle for the zero counter: the vector to scan and its count/empty result.
// The counter drives the result, so it takes the slave side.
interface lzc_if #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
  logic [WIDTH-1:0]     in_i;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 empty_o;

  modport master (output in_i, input cnt_o, empty_o);
  modport slave  (input in_i, output cnt_o, empty_o);
endinterface

// File: rtl/lzc.sv
// Zero-latency leading/trailing zero counter built as a log2 selection tree.
// MODE=1 reverses the input so the same trailing-zero tree serves both ends.
module lzc #(
  parameter  int WIDTH     = 2,
  parameter  int MODE      = 0,
  localparam int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  lzc_if.slave  bus
);

  localparam int LEAVES = 1 << CNT_WIDTH;
  localparam int NODES  = 2 * LEAVES - 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("lzc: WIDTH must be >= 1");
  end

  logic [LEAVES-1:0]    leaf_bits;
  logic                 node_vld [NODES];
  logic [CNT_WIDTH-1:0] node_idx [NODES];

  // Leaves past WIDTH-1 are tied off so they can never win the search.
  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i >= WIDTH) begin : g_pad
      assign leaf_bits[i] = 1'b0;
    end else if (MODE == 0) begin : g_fwd
      assign leaf_bits[i] = bus.in_i[i];
    end else begin : g_rev
      assign leaf_bits[i] = bus.in_i[WIDTH-1-i];
    end
  end

  // Heap layout: node k has children 2k+1 (lower indices) and 2k+2; leaves
  // sit at LEAVES-1.. . Evaluated bottom-up so every child is ready first.
  always_comb begin
    for (int i = 0; i < LEAVES; i++) begin
      node_vld[LEAVES-1+i] = leaf_bits[i];
      node_idx[LEAVES-1+i] = '0;
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      node_vld[k] = node_vld[2*k+1] | node_vld[2*k+2];
      node_idx[k] = node_vld[2*k+1]
                  ? node_idx[2*k+1]
                  : (node_idx[2*k+2] | (CNT_WIDTH'(1) << (CNT_WIDTH - $clog2(k + 2))));
    end
  end

  // An invalid root would point at the last padded leaf; force 0 instead.
  assign bus.cnt_o   = node_vld[0] ? node_idx[0] : '0;
  assign bus.empty_o = ~|bus.in_i;

`ifndef SYNTHESIS
  logic [WIDTH-1:0] hit_mask;
  logic [WIDTH-1:0] end_mask;
  int               pos;

  // NOTE: every variable gets a default before the loop, so no latch is inferred.
  always_comb begin
    hit_mask = '0;
    end_mask = '0;
    pos      = (MODE == 0) ? int'(bus.cnt_o) : (WIDTH - 1 - int'(bus.cnt_o));
    for (int k = 0; k < WIDTH; k++) begin
      hit_mask[k] = (k == pos);
      end_mask[k] = (MODE == 0) ? (k < pos) : (k > pos);
    end
  end

  a_first_set: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !bus.empty_o |-> |(bus.in_i & hit_mask));

  a_zeros_before: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !bus.empty_o |-> ((bus.in_i & end_mask) == '0));
`endif

endmodule

// File: tb/tb_lzc.sv
// Drives one shared vector into fourteen lzc instances (several widths, both
// modes) and scoreboards each result against constants or a reference loop.
module tb_lzc;

  localparam int N = 14;
  localparam int WS [N] = '{8, 8, 5, 5, 1, 1, 2, 2, 3, 3, 7, 7, 16, 16};

  typedef struct packed {
    logic [15:0] vec;
    logic [3:0]  inst;
    logic [4:0]  cnt;
    logic        empty;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] stim;
  logic [31:0] cnt_obs   [N];
  logic        empty_obs [N];

  exp_t exp_q [$];
  int   checks;
  int   errors;

  for (genvar g = 0; g < N; g++) begin : g_dut
    lzc_if #(.WIDTH(WS[g])) bus ();
    assign bus.in_i = stim[WS[g]-1:0];
    lzc #(.WIDTH(WS[g]), .MODE(g % 2)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
    );
    assign cnt_obs[g]   = 32'(bus.cnt_o);
    assign empty_obs[g] = bus.empty_o;
  end

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int ref_cnt(logic [15:0] v, int w, int mode);
    for (int i = 0; i < w; i++) begin
      int b;
      b = (mode != 0) ? (w - 1 - i) : i;
      if (v[b]) return i;
    end
    return 0;
  endfunction

  task automatic push_exp(int inst, int cnt, logic empty);
    exp_t e;
    e.vec   = stim;
    e.inst  = 4'(inst);
    e.cnt   = 5'(cnt);
    e.empty = empty;
    exp_q.push_back(e);
  endtask

  task automatic push_model();
    logic [15:0] m;
    for (int g = 0; g < N; g++) begin
      m = 16'((32'd1 << WS[g]) - 1);
      push_exp(g, ref_cnt(stim, WS[g], g % 2), (stim & m) == 16'h0);
    end
  endtask

  // Outputs are combinational: sample 1 ns after the drive, away from clk edges.
  task automatic drain(string tag);
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (cnt_obs[e.inst] !== 32'(e.cnt)) begin
        errors++;
        $display("FAIL %s cnt inst=%0d W=%0d vec=%h got=%0d exp=%0d",
                 tag, e.inst, WS[e.inst], e.vec, cnt_obs[e.inst], e.cnt);
      end
      checks++;
      if (empty_obs[e.inst] !== e.empty) begin
        errors++;
        $display("FAIL %s empty inst=%0d W=%0d vec=%h got=%b exp=%b",
                 tag, e.inst, WS[e.inst], e.vec, empty_obs[e.inst], e.empty);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    stim   = 16'h0028;
    push_exp(0, 3, 1'b0);
    push_exp(1, 2, 1'b0);
    drain("reset_held");
    rst_ni = 1'b1;
    drain("reset_release");
    stim = 16'h0028;
    push_exp(0, 3, 1'b0);
    push_exp(1, 2, 1'b0);
    drain("reset_after");
  endtask

  task automatic test_basic();
    stim = 16'h0028;
    push_exp(0, 3, 1'b0);
    push_exp(1, 2, 1'b0);
    drain("basic_w8");
  endtask

  task automatic test_empty();
    stim = 16'h0000;
    push_exp(0, 0, 1'b1);
    push_exp(1, 0, 1'b1);
    drain("empty_w8");
  endtask

  task automatic test_boundary();
    stim = 16'h0080;
    push_exp(0, 7, 1'b0);
    drain("msb_tz");
    stim = 16'h00FF;
    push_exp(0, 0, 1'b0);
    drain("ones_tz");
    stim = 16'h0001;
    push_exp(1, 7, 1'b0);
    drain("lsb_lz");
  endtask

  task automatic test_width5();
    stim = 16'h0010;
    push_exp(2, 4, 1'b0);
    push_exp(3, 0, 1'b0);
    drain("w5_top");
    stim = 16'h0001;
    push_exp(3, 4, 1'b0);
    drain("w5_bottom_lz");
  endtask

  task automatic test_width1();
    stim = 16'h0001;
    push_exp(4, 0, 1'b0);
    push_exp(5, 0, 1'b0);
    drain("w1_set");
    stim = 16'h0000;
    push_exp(4, 0, 1'b1);
    push_exp(5, 0, 1'b1);
    drain("w1_clear");
  endtask

  // Back-to-back vectors with no idle gap; reset is pulsed partway through.
  task automatic test_sweep();
    for (int v = 0; v < 65536; v++) begin
      stim = 16'(v);
      if (v == 20000) rst_ni = 1'b0;
      if (v == 20050) rst_ni = 1'b1;
      push_model();
      drain("sweep");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    stim   = 16'h0000;
    #11;
    test_reset();
    test_basic();
    test_empty();
    test_boundary();
    test_width5();
    test_width1();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
